// File: rtl/store_buffer.sv
// MEM-stage store path: narrows rt store data onto byte lanes, generates byte enables,
// and queues stores in a small FIFO drained to data memory over a req/ack handshake.
module store_buffer #(
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     st_valid,
  output logic                     st_ready,
  input  logic [31:0]              st_addr,
  input  logic [31:0]              st_data,
  input  logic [1:0]               st_type,
  output logic                     misaligned,
  output logic                     mem_req,
  input  logic                     mem_ack,
  output logic [31:0]              mem_addr,
  output logic [31:0]              mem_wdata,
  output logic [3:0]               mem_be,
  input  logic                     ld_valid,
  input  logic [31:0]              ld_addr,
  output logic                     ld_hazard,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned PW = $clog2(DEPTH);

  localparam logic [1:0] TYPE_WORD = 2'b00;
  localparam logic [1:0] TYPE_HALF = 2'b01;
  localparam logic [1:0] TYPE_BYTE = 2'b10;

  logic [29:0]   addr_q [DEPTH];
  logic [31:0]   data_q [DEPTH];
  logic [3:0]    be_q   [DEPTH];

  logic [PW-1:0] rd_ptr_q, wr_ptr_q;
  logic [PW:0]   count_q, count_d;

  logic [31:0]   lane_data;
  logic [3:0]    lane_be;
  logic          full, enq, deq;

  // Narrow and replicate the store onto byte lanes.
  always_comb begin
    lane_data = st_data;
    lane_be   = 4'b0000;
    case (st_type)
      TYPE_WORD: begin
        lane_data = st_data;
        lane_be   = 4'b1111;
      end
      TYPE_HALF: begin
        lane_data = {2{st_data[15:0]}};
        lane_be   = st_addr[1] ? 4'b1100 : 4'b0011;
      end
      TYPE_BYTE: begin
        lane_data = {4{st_data[7:0]}};
        lane_be   = 4'b0001 << st_addr[1:0];
      end
      default: begin
        lane_data = st_data;
        lane_be   = 4'b0000;
      end
    endcase
  end

  always_comb begin
    misaligned = st_valid & ((st_type == 2'b11) |
                             ((st_type == TYPE_HALF) & st_addr[0]) |
                             ((st_type == TYPE_WORD) & (|st_addr[1:0])));
  end

  always_comb begin
    full     = (count_q == (PW+1)'(DEPTH));
    st_ready = ~full;
    mem_req  = (count_q != '0);
    enq      = st_valid & ~full & ~misaligned;
    deq      = mem_req & mem_ack;
    count_d  = count_q;
    if (enq && !deq) begin
      count_d = count_q + (PW+1)'(1);
    end else if (deq && !enq) begin
      count_d = count_q - (PW+1)'(1);
    end
  end

  // Head outputs read zero whenever nothing is pending.
  always_comb begin
    mem_addr  = 32'h0;
    mem_wdata = 32'h0;
    mem_be    = 4'h0;
    if (mem_req) begin
      mem_addr  = {addr_q[rd_ptr_q], 2'b00};
      mem_wdata = data_q[rd_ptr_q];
      mem_be    = be_q[rd_ptr_q];
    end
  end

  // An entry is held when its distance from the read pointer is below count.
  always_comb begin
    logic [PW-1:0] offs;
    ld_hazard = 1'b0;
    offs      = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      offs = PW'(i) - rd_ptr_q;
      if (({1'b0, offs} < count_q) && (addr_q[i] == ld_addr[31:2])) begin
        ld_hazard = 1'b1;
      end
    end
    ld_hazard = ld_hazard & ld_valid;
  end

  always_ff @(posedge clk) begin
    if (enq) begin
      addr_q[wr_ptr_q] <= st_addr[31:2];
      data_q[wr_ptr_q] <= lane_data;
      be_q[wr_ptr_q]   <= lane_be;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (enq) begin
        wr_ptr_q <= wr_ptr_q + PW'(1);
      end
      if (deq) begin
        rd_ptr_q <= rd_ptr_q + PW'(1);
      end
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: tb/tb_store_buffer.sv
// Directed and randomized bench for store_buffer, checked against a queue-based model.
module tb_store_buffer;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset, st_valid, mem_ack, ld_valid;
  logic [31:0] st_addr, st_data, ld_addr;
  logic [1:0]  st_type;
  logic        st_ready, misaligned, mem_req, ld_hazard;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_be;
  logic [2:0]  count;

  store_buffer #(.DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .st_valid(st_valid), .st_ready(st_ready),
    .st_addr(st_addr), .st_data(st_data), .st_type(st_type), .misaligned(misaligned),
    .mem_req(mem_req), .mem_ack(mem_ack), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_be(mem_be), .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_hazard(ld_hazard),
    .count(count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  be;
  } ent_t;

  ent_t q[$];
  int n_assert = 0;
  int n_fail   = 0;
  int n_writes = 0;

  function automatic int size_of(input logic [1:0] t);
    case (t)
      2'b00:   return 4;
      2'b01:   return 2;
      2'b10:   return 1;
      default: return 0;
    endcase
  endfunction

  function automatic logic exp_mis();
    int sz;
    if (!st_valid) return 1'b0;
    sz = size_of(st_type);
    if (sz == 0) return 1'b1;
    return (int'(st_addr[1:0]) % sz) != 0;
  endfunction

  // Lane k carries data byte (k mod size); enabled lanes span [offset, offset+size).
  function automatic ent_t make_ent();
    ent_t e;
    int sz, off;
    sz = size_of(st_type);
    off = int'(st_addr[1:0]);
    e.addr = {st_addr[31:2], 2'b00};
    e.data = '0;
    e.be   = '0;
    if (sz != 0) begin
      for (int k = 0; k < 4; k++) begin
        e.data[8*k +: 8] = st_data[8*(k % sz) +: 8];
        e.be[k] = (k >= off) && (k < off + sz);
      end
    end
    return e;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Check all outputs against the model, then advance one clock and update the model.
  task automatic cycle();
    logic hz;
    logic acc, deq;
    ent_t e;
    #1;
    hz = 1'b0;
    foreach (q[i]) if (q[i].addr[31:2] == ld_addr[31:2]) hz = 1'b1;
    hz = hz & ld_valid;
    check("count", 32'(count), 32'(q.size()));
    check("st_ready", 32'(st_ready), 32'(q.size() != DEPTH));
    check("mem_req", 32'(mem_req), 32'(q.size() != 0));
    check("mem_addr", mem_addr, q.size() != 0 ? q[0].addr : 32'h0);
    check("mem_wdata", mem_wdata, q.size() != 0 ? q[0].data : 32'h0);
    check("mem_be", 32'(mem_be), q.size() != 0 ? 32'(q[0].be) : 32'h0);
    check("misaligned", 32'(misaligned), 32'(exp_mis()));
    check("ld_hazard", 32'(ld_hazard), 32'(hz));
    acc = st_valid && (q.size() != DEPTH) && !exp_mis();
    deq = (q.size() != 0) && mem_ack;
    e = make_ent();
    @(posedge clk);
    if (reset) begin
      q.delete();
    end else begin
      if (deq) begin
        void'(q.pop_front());
        n_writes++;
      end
      if (acc) q.push_back(e);
    end
    #1;
  endtask

  task automatic drain();
    st_valid = 1'b0;
    ld_valid = 1'b0;
    mem_ack  = 1'b1;
    for (int i = 0; i < 20 && q.size() != 0; i++) cycle();
    check("drain_empty", 32'(count), 32'h0);
    mem_ack = 1'b0;
  endtask

  task automatic set_store(input logic [1:0] t, input logic [31:0] a, input logic [31:0] d);
    st_valid = 1'b1;
    st_type  = t;
    st_addr  = a;
    st_data  = d;
  endtask

  initial begin
    int w0;
    reset = 1'b1; st_valid = 1'b0; mem_ack = 1'b0; ld_valid = 1'b0;
    st_addr = '0; st_data = '0; st_type = '0; ld_addr = '0;
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b0;
    q.delete();
    #1;
    check("rst_count", 32'(count), 32'h0);
    check("rst_ready", 32'(st_ready), 32'h1);
    check("rst_req", 32'(mem_req), 32'h0);
    check("rst_addr", mem_addr, 32'h0);

    // 1: byte store
    set_store(2'b10, 32'h0000_1003, 32'hAABB_CCDD);
    cycle();
    st_valid = 1'b0;
    check("t1_req", 32'(mem_req), 32'h1);
    check("t1_addr", mem_addr, 32'h0000_1000);
    check("t1_wdata", mem_wdata, 32'hDDDD_DDDD);
    check("t1_be", 32'(mem_be), 32'h8);
    drain();

    // 2: half store, then misaligned half
    set_store(2'b01, 32'h0000_2002, 32'h1234_5678);
    cycle();
    st_valid = 1'b0;
    check("t2_wdata", mem_wdata, 32'h5678_5678);
    check("t2_be", 32'(mem_be), 32'hC);
    set_store(2'b01, 32'h0000_2001, 32'h1234_5678);
    #1;
    check("t2_mis", 32'(misaligned), 32'h1);
    cycle();
    check("t2_count", 32'(count), 32'h1);
    drain();

    // 3: fill, hold fifth, one ack
    for (int i = 0; i < DEPTH; i++) begin
      set_store(2'b00, 32'h100 + 32'(4 * i), 32'hC0DE_0000 + 32'(i));
      cycle();
    end
    check("t3_full", 32'(count), 32'h4);
    check("t3_ready", 32'(st_ready), 32'h0);
    set_store(2'b00, 32'h200, 32'hFEED_FACE);
    cycle();
    check("t3_held", 32'(count), 32'h4);
    mem_ack = 1'b1;
    cycle();
    mem_ack = 1'b0;
    check("t3_pop", 32'(count), 32'h3);
    check("t3_ready1", 32'(st_ready), 32'h1);
    check("t3_head", mem_addr, 32'h104);
    cycle();
    check("t3_accept", 32'(count), 32'h4);
    drain();

    // 4: load hazard
    set_store(2'b00, 32'h3004, 32'h1111_2222);
    cycle();
    st_valid = 1'b0;
    ld_valid = 1'b1;
    ld_addr  = 32'h3006;
    #1;
    check("t4_hz1", 32'(ld_hazard), 32'h1);
    ld_addr = 32'h3008;
    #1;
    check("t4_hz0", 32'(ld_hazard), 32'h0);
    set_store(2'b00, 32'h3008, 32'h3333_4444);
    cycle();
    drain();

    // 5: back-to-back with ack held
    mem_ack = 1'b1;
    w0 = n_writes;
    for (int i = 0; i < 10; i++) begin
      set_store(2'b00, 32'h5000 + 32'(4 * i), 32'($urandom));
      cycle();
    end
    st_valid = 1'b0;
    cycle();
    check("t5_writes", 32'(n_writes - w0), 32'd10);
    drain();

    // 6: reset with entries queued mid-handshake
    for (int i = 0; i < 3; i++) begin
      set_store(2'b10, 32'h6000 + 32'(i), 32'($urandom));
      cycle();
    end
    st_valid = 1'b0;
    reset = 1'b1;
    mem_ack = 1'b1;
    cycle();
    reset = 1'b0;
    mem_ack = 1'b0;
    check("t6_count", 32'(count), 32'h0);
    check("t6_req", 32'(mem_req), 32'h0);
    check("t6_ready", 32'(st_ready), 32'h1);

    // Random traffic over a small address pool so hazards occur.
    for (int i = 0; i < 400; i++) begin
      st_valid = ($urandom_range(0, 9) < 6);
      st_type  = 2'($urandom_range(0, 3));
      st_addr  = 32'h4000 + 32'($urandom_range(0, 7) * 4) + 32'($urandom_range(0, 3));
      st_data  = $urandom;
      ld_valid = ($urandom_range(0, 1) == 1);
      ld_addr  = 32'h4000 + 32'($urandom_range(0, 7) * 4) + 32'($urandom_range(0, 3));
      mem_ack  = ($urandom_range(0, 2) != 0);
      reset    = ($urandom_range(0, 63) == 0);
      cycle();
    end
    reset = 1'b0;
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
